// File: rtl/barrel_shifter_rshift_pipe.sv
// ----------------------------------------------------------------------------
// barrel_shifter_rshift_pipe
//   Pipelined right barrel shifter: logical, arithmetic or rotate right.
//   Stage s shifts right by 2^s when bit s of the shift amount is set, so
//   SHW = log2(WIDTH) registered stages cover every amount 0..WIDTH-1.
//   A valid/ready handshake with per-stage valid bits lets bubbles collapse
//   and lets the pipe fill up behind a stalled consumer.
// ----------------------------------------------------------------------------
module barrel_shifter_rshift_pipe #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_ctrl,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [SHW-1:0]   out_ctrl
);

  // Shift flavours. Encoding 2'b11 is folded onto MODE_LSR at the input,
  // so the stages only ever see the three legal values.
  typedef enum logic [1:0] {
    MODE_LSR = 2'b00,
    MODE_ASR = 2'b01,
    MODE_ROR = 2'b10
  } shift_mode_e;

  // Per-stage pipeline registers.
  logic [SHW-1:0]   v_q;
  logic [WIDTH-1:0] d_q [SHW];
  logic [SHW-1:0]   c_q [SHW];
  shift_mode_e      m_q [SHW];

  // Advance chain; adv[SHW] is the downstream ready.
  logic [SHW:0]     adv;

  // What each stage would load: stage 0 sees the ports, stage s sees s-1.
  logic [SHW-1:0]   src_v;
  logic [WIDTH-1:0] src_d [SHW];
  logic [SHW-1:0]   src_c [SHW];
  shift_mode_e      src_m [SHW];

  // Result of each stage's conditional shift, registered on advance.
  logic [WIDTH-1:0] sh_d  [SHW];

  shift_mode_e      in_mode_n;

  // Fold the reserved mode encoding onto logical shift.
  assign in_mode_n = (in_mode == 2'b11) ? MODE_LSR : shift_mode_e'(in_mode);

  // Ready propagates backwards: a stage may load if it is empty or if the
  // stage after it is moving this cycle.
  always_comb begin
    // NOTE: every combinational output gets a default before any conditional
    // logic, so no path leaves it unassigned and no latch is inferred.
    adv      = '0;
    adv[SHW] = out_ready;
    for (int s = SHW - 1; s >= 0; s--) begin
      adv[s] = !v_q[s] || adv[s+1];
    end
  end

  // Route each stage's source: the input ports for stage 0, the previous
  // stage's registers otherwise.
  always_comb begin
    src_v    = '0;
    src_v[0] = in_valid;
    src_d[0] = in_data;
    src_c[0] = in_ctrl;
    src_m[0] = in_mode_n;
    for (int s = 1; s < SHW; s++) begin
      src_v[s] = v_q[s-1];
      src_d[s] = d_q[s-1];
      src_c[s] = c_q[s-1];
      src_m[s] = m_q[s-1];
    end
  end

  // Stage s shifts right by 2^s when shift-amount bit s is set. The
  // arithmetic fill copies the MSB of the word entering the stage; since an
  // arithmetic shift keeps that MSB, the original sign survives every stage.
  always_comb begin
    for (int s = 0; s < SHW; s++) begin
      sh_d[s] = src_d[s];
      if (src_c[s][s]) begin
        case (src_m[s])
          MODE_ASR: sh_d[s] = $signed(src_d[s]) >>> (1 << s);
          MODE_ROR: sh_d[s] = (src_d[s] >> (1 << s))
                            | (src_d[s] << (WIDTH - (1 << s)));
          default:  sh_d[s] = src_d[s] >> (1 << s);
        endcase
      end
    end
  end

  // Pipeline registers: load on advance, clear everything on reset so an
  // aborted word can never leak out as a partial result.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples its predecessor's pre-edge value, exactly like real flops.
    if (rst) begin
      // NOTE: data/ctrl/mode are cleared along with the valid bits so the
      // output ports read zero after reset; only v_q is functionally needed.
      v_q <= '0;
      for (int s = 0; s < SHW; s++) begin
        d_q[s] <= '0;
        c_q[s] <= '0;
        m_q[s] <= MODE_LSR;
      end
    end else begin
      for (int s = 0; s < SHW; s++) begin
        if (adv[s]) begin
          v_q[s] <= src_v[s];
          d_q[s] <= sh_d[s];
          c_q[s] <= src_c[s];
          m_q[s] <= src_m[s];
        end
      end
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = v_q[SHW-1];
  assign out_data  = d_q[SHW-1];
  assign out_ctrl  = c_q[SHW-1];

endmodule
